// File: rtl/stripe_pattern_gen.sv
// stripe_pattern_gen: two-stage RGB565 test-pattern generator (stripes, checkerboard, colour bars)
// with a frame-synchronised mode handshake. Define STRIPE_SCROLL_EN to enable per-frame horizontal scroll.
module stripe_pattern_gen #(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned STRIPE_SHIFT = 6,
    parameter int unsigned SCROLL_STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_i,
    input  logic [WIDTH-1:0] line_coo,
    input  logic [WIDTH-1:0] ver_coo,
    input  logic             frame_start,
    input  logic [1:0]       mode_req,
    input  logic             mode_valid,
    output logic             mode_ready,
    output logic [1:0]       mode_o,
    output logic [15:0]      rgb_o,
    output logic             de_o
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned RGB_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         pend_q, pend_d;
    logic               ready_q, ready_d;
    logic               accept;

    logic [WIDTH-1:0]   offset;
    logic [WIDTH-1:0]   x_sum;
    logic [WIDTH-1:0]   x_tile;
    logic [WIDTH-1:0]   y_tile;

    logic [IDX_W-1:0]   idx_d, idx_q;
    logic               de1_q;
    logic [RGB_W-1:0]   rgb_d, rgb_q;
    logic               de2_q;

    if (STRIPE_SHIFT < 1 || STRIPE_SHIFT >= WIDTH || SCROLL_STEP >= (32'd1 << WIDTH)) begin : g_param_check
        $error("stripe_pattern_gen: illegal parameter combination");
    end

    // Colour-bar index: bar bounds fold to constants at elaboration.
    function automatic logic [IDX_W-1:0] bar_index(input logic [WIDTH-1:0] x);
        logic [IDX_W-1:0] k;
        k = '0;
        for (int unsigned b = 1; b < 8; b++) begin
            if (32'(x) >= (b * H_ACTIVE) / 8) begin
                k = IDX_W'(b);
            end
        end
        if (32'(x) >= H_ACTIVE) begin
            k = 3'd7;
        end
        return k;
    endfunction

    function automatic logic [RGB_W-1:0] palette(input logic [IDX_W-1:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = 16'hF800;
            3'd1:    c = 16'h07E0;
            3'd2:    c = 16'h001F;
            3'd3:    c = 16'hFFFF;
            3'd4:    c = 16'hFFE0;
            3'd5:    c = 16'h07FF;
            3'd6:    c = 16'hF81F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

`ifdef STRIPE_SCROLL_EN
    logic [WIDTH-1:0] offset_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
        end else if (frame_start) begin
            offset_q <= offset_q + WIDTH'(SCROLL_STEP);
        end
    end

    assign offset = offset_q;
`else
    assign offset = '0;
`endif

    // Mode handshake: accepted mode waits for frame_start unless it arrives with it.
    assign accept = mode_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            pend_q  <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (frame_start) begin
                        mode_d = mode_req;
                    end else begin
                        pend_d  = mode_req;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (frame_start) begin
                    mode_d  = pend_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Stage 1: palette index from coordinates under the mode in effect this cycle.
    assign x_sum  = line_coo + offset;
    assign x_tile = x_sum >> STRIPE_SHIFT;
    assign y_tile = ver_coo >> STRIPE_SHIFT;

    always_comb begin
        idx_d = 3'd7;
        case (mode_q)
            2'd0:    idx_d = IDX_W'(x_tile % WIDTH'(3));
            2'd1:    idx_d = IDX_W'(y_tile % WIDTH'(3));
            2'd2:    idx_d = (x_tile[0] ^ y_tile[0]) ? 3'd3 : 3'd7;
            default: idx_d = bar_index(line_coo);
        endcase
    end

    // Stage 2: blank outside active video.
    assign rgb_d = de1_q ? palette(idx_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            de1_q <= 1'b0;
            rgb_q <= '0;
            de2_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            de1_q <= de_i;
            rgb_q <= rgb_d;
            de2_q <= de1_q;
        end
    end

    assign mode_ready = ready_q;
    assign mode_o     = mode_q;
    assign rgb_o      = rgb_q;
    assign de_o       = de2_q;

endmodule

// File: tb/tb_stripe_pattern_gen.sv
// Directed self-checking bench for stripe_pattern_gen (default parameters).
module tb_stripe_pattern_gen;

    localparam int unsigned WIDTH = 10;

    logic             clk         = 1'b0;
    logic             rst         = 1'b1;
    logic             de_i        = 1'b0;
    logic [WIDTH-1:0] line_coo    = '0;
    logic [WIDTH-1:0] ver_coo     = '0;
    logic             frame_start = 1'b0;
    logic [1:0]       mode_req    = '0;
    logic             mode_valid  = 1'b0;
    logic             mode_ready;
    logic [1:0]       mode_o;
    logic [15:0]      rgb_o;
    logic             de_o;

    int n_checks = 0;
    int n_fail   = 0;

    stripe_pattern_gen #(
        .WIDTH(10),
        .H_ACTIVE(640),
        .STRIPE_SHIFT(6),
        .SCROLL_STEP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .de_i(de_i),
        .line_coo(line_coo),
        .ver_coo(ver_coo),
        .frame_start(frame_start),
        .mode_req(mode_req),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .mode_o(mode_o),
        .rgb_o(rgb_o),
        .de_o(de_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic de);
        line_coo = x;
        ver_coo  = y;
        de_i     = de;
        tick();
        tick();
    endtask

    task automatic test_reset();
        de_i     = 1'b1;
        line_coo = 10'd64;
        tick(); tick(); tick();
        n_checks++; if (rgb_o !== 16'h0000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 0000", rgb_o); end
        n_checks++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b expected 0", de_o); end
        n_checks++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode_o); end
        n_checks++; if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", mode_ready); end
        rst  = 1'b0;
        de_i = 1'b0;
        tick();
        n_checks++; if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", mode_ready); end
    endtask

    task automatic test_vstripes();
        logic [WIDTH-1:0] xs [5];
        logic [15:0]      ex [5];
        xs = '{10'd0, 10'd64, 10'd128, 10'd192, 10'd63};
        ex = '{16'hF800, 16'h07E0, 16'h001F, 16'hF800, 16'hF800};
        for (int i = 0; i < 5; i++) begin
            drive_px(xs[i], 10'd0, 1'b1);
            n_checks++; if (rgb_o !== ex[i]) begin n_fail++; $display("FAIL vstripe_rgb x=%0d: got %h expected %h", xs[i], rgb_o, ex[i]); end
            n_checks++; if (de_o !== 1'b1) begin n_fail++; $display("FAIL vstripe_de x=%0d: got %b expected 1", xs[i], de_o); end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] xs [6];
        logic             ds [6];
        logic [15:0]      ex [6];
        xs = '{10'd0, 10'd64, 10'd128, 10'd192, 10'd100, 10'd130};
        ds = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ex = '{16'hF800, 16'h07E0, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                n_checks++; if (rgb_o !== ex[i-2]) begin n_fail++; $display("FAIL b2b_rgb[%0d]: got %h expected %h", i-2, rgb_o, ex[i-2]); end
                n_checks++; if (de_o !== ds[i-2]) begin n_fail++; $display("FAIL b2b_de[%0d]: got %b expected %b", i-2, de_o, ds[i-2]); end
            end
            if (i < 6) begin
                line_coo = xs[i];
                ver_coo  = 10'd0;
                de_i     = ds[i];
            end else begin
                de_i = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_mode_coincident();
        logic [WIDTH-1:0] ys [5];
        logic [15:0]      ex [5];
        mode_valid  = 1'b1;
        mode_req    = 2'd1;
        frame_start = 1'b1;
        tick();
        mode_valid  = 1'b0;
        frame_start = 1'b0;
        n_checks++; if (mode_o !== 2'd1) begin n_fail++; $display("FAIL coincident_mode: got %0d expected 1", mode_o); end
        n_checks++; if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL coincident_ready: got %b expected 1", mode_ready); end
        ys = '{10'd0, 10'd64, 10'd128, 10'd200, 10'd63};
        ex = '{16'hF800, 16'h07E0, 16'h001F, 16'hF800, 16'hF800};
        for (int i = 0; i < 5; i++) begin
            drive_px(10'd5, ys[i], 1'b1);
            n_checks++; if (rgb_o !== ex[i]) begin n_fail++; $display("FAIL hstripe_rgb y=%0d: got %h expected %h", ys[i], rgb_o, ex[i]); end
        end
    endtask

    task automatic test_colour_bars();
        logic [WIDTH-1:0] xs [7];
        logic [15:0]      ex [7];
        mode_valid  = 1'b1;
        mode_req    = 2'd3;
        frame_start = 1'b1;
        tick();
        mode_valid  = 1'b0;
        frame_start = 1'b0;
        n_checks++; if (mode_o !== 2'd3) begin n_fail++; $display("FAIL bars_mode: got %0d expected 3", mode_o); end
        xs = '{10'd79, 10'd80, 10'd639, 10'd320, 10'd700, 10'd159, 10'd160};
        ex = '{16'hF800, 16'h07E0, 16'h0000, 16'hFFE0, 16'h0000, 16'h07E0, 16'h001F};
        for (int i = 0; i < 7; i++) begin
            drive_px(xs[i], 10'd33, 1'b1);
            n_checks++; if (rgb_o !== ex[i]) begin n_fail++; $display("FAIL bars_rgb x=%0d: got %h expected %h", xs[i], rgb_o, ex[i]); end
        end
        drive_px(10'd80, 10'd33, 1'b0);
        n_checks++; if (rgb_o !== 16'h0000) begin n_fail++; $display("FAIL bars_blank_rgb: got %h expected 0000", rgb_o); end
        n_checks++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL bars_blank_de: got %b expected 0", de_o); end
    endtask

    task automatic test_mode_pending();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mode_valid = 1'b1;
        mode_req   = 2'd2;
        tick();
        mode_valid = 1'b0;
        n_checks++; if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready: got %b expected 0", mode_ready); end
        n_checks++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL pend_mode_held: got %0d expected 0", mode_o); end
        drive_px(10'd64, 10'd0, 1'b1);
        n_checks++; if (rgb_o !== 16'h07E0) begin n_fail++; $display("FAIL pend_old_mode_rgb: got %h expected 07E0", rgb_o); end
        n_checks++; if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready_still: got %b expected 0", mode_ready); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++; if (mode_o !== 2'd2) begin n_fail++; $display("FAIL pend_load_mode: got %0d expected 2", mode_o); end
        n_checks++; if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL pend_ready_back: got %b expected 1", mode_ready); end
        drive_px(10'd64, 10'd0, 1'b1);
        n_checks++; if (rgb_o !== 16'hFFFF) begin n_fail++; $display("FAIL checker_64_0: got %h expected FFFF", rgb_o); end
        drive_px(10'd0, 10'd0, 1'b1);
        n_checks++; if (rgb_o !== 16'h0000) begin n_fail++; $display("FAIL checker_0_0: got %h expected 0000", rgb_o); end
        n_checks++; if (de_o !== 1'b1) begin n_fail++; $display("FAIL checker_0_0_de: got %b expected 1", de_o); end
        // Pixel entering on the switching edge must finish under the old mode.
        mode_valid = 1'b1;
        mode_req   = 2'd1;
        tick();
        mode_valid  = 1'b0;
        frame_start = 1'b1;
        line_coo    = 10'd0;
        ver_coo     = 10'd64;
        de_i        = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++; if (mode_o !== 2'd1) begin n_fail++; $display("FAIL switch_mode: got %0d expected 1", mode_o); end
        tick();
        n_checks++; if (rgb_o !== 16'hFFFF) begin n_fail++; $display("FAIL switch_inflight_rgb: got %h expected FFFF", rgb_o); end
        drive_px(10'd0, 10'd64, 1'b1);
        n_checks++; if (rgb_o !== 16'h07E0) begin n_fail++; $display("FAIL switch_new_rgb: got %h expected 07E0", rgb_o); end
    endtask

    task automatic test_reset_pending();
        mode_valid = 1'b1;
        mode_req   = 2'd3;
        tick();
        mode_valid = 1'b0;
        n_checks++; if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL rstpend_ready: got %b expected 0", mode_ready); end
        line_coo = 10'd80;
        ver_coo  = 10'd0;
        de_i     = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (rgb_o !== 16'h0000) begin n_fail++; $display("FAIL rstpend_rgb: got %h expected 0000", rgb_o); end
        n_checks++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL rstpend_de: got %b expected 0", de_o); end
        n_checks++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL rstpend_mode: got %0d expected 0", mode_o); end
        n_checks++; if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL rstpend_ready_in_rst: got %b expected 0", mode_ready); end
        de_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL rstpend_release_ready: got %b expected 1", mode_ready); end
        n_checks++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL rstpend_release_mode: got %0d expected 0", mode_o); end
        n_checks++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL rstpend_release_de: got %b expected 0", de_o); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++; if (mode_o !== 2'd0) begin n_fail++; $display("FAIL rstpend_discarded: got %0d expected 0", mode_o); end
    endtask

    task automatic test_scroll();
        logic [15:0] exp64;
`ifdef STRIPE_SCROLL_EN
        exp64 = 16'h07E0;
`else
        exp64 = 16'hF800;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
        drive_px(10'd0, 10'd0, 1'b1);
        n_checks++; if (rgb_o !== exp64) begin n_fail++; $display("FAIL scroll_64: got %h expected %h", rgb_o, exp64); end
        for (int i = 0; i < 960; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
        drive_px(10'd0, 10'd0, 1'b1);
        n_checks++; if (rgb_o !== 16'hF800) begin n_fail++; $display("FAIL scroll_wrap: got %h expected F800", rgb_o); end
    endtask

    initial begin
        test_reset();
        test_vstripes();
        test_back_to_back();
        test_mode_coincident();
        test_colour_bars();
        test_mode_pending();
        test_reset_pending();
        test_scroll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stripe_pattern_gen.md
STRIPE_PATTERN_GEN -- requirements
Module: stripe_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 10: coordinate width in bits.
REQ-002 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-003 Parameter STRIPE_SHIFT, default 6: stripe/tile size is 2^STRIPE_SHIFT pixels; legal range 1..WIDTH-1.
REQ-004 Parameter SCROLL_STEP, default 1: pixels of horizontal scroll added per frame.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous and active-high.
REQ-007 Port de_i, input, 1: active-video qualifier for the current coordinates.
REQ-008 Port line_coo, input, WIDTH: horizontal pixel coordinate (x).
REQ-009 Port ver_coo, input, WIDTH: vertical line coordinate (y).
REQ-010 Port frame_start, input, 1: single-cycle pulse at the start of each frame.
REQ-011 Port mode_req, input, 2: requested pattern mode.
REQ-012 Port mode_valid, input, 1: mode_req valid.
REQ-013 Port mode_ready, output, 1: block can accept a mode request.
REQ-014 Port mode_o, output, 2: mode currently in effect.
REQ-015 Port rgb_o, output, 16: RGB565 pixel.
REQ-016 Port de_o, output, 1: de_i delayed to align with rgb_o.

Function
REQ-017 Palette index to RGB565 SHALL be: 0 F800, 1 07E0, 2 001F, 3 FFFF, 4 FFE0, 5 07FF, 6 F81F, 7 0000.
REQ-018 Mode 0 (vertical stripes) SHALL use palette index ((x + offset) >> STRIPE_SHIFT) mod 3, x-sum truncated to WIDTH bits.
REQ-019 Mode 1 (horizontal stripes) SHALL use palette index (y >> STRIPE_SHIFT) mod 3.
REQ-020 Mode 2 (checkerboard) SHALL output FFFF when bit 0 of (((x + offset) >> STRIPE_SHIFT) XOR (y >> STRIPE_SHIFT)) is 1, else 0000.
REQ-021 Mode 3 (colour bars) SHALL use palette index k for k*H_ACTIVE/8 <= x < (k+1)*H_ACTIVE/8, with bounds as elaboration-time constants; x >= H_ACTIVE gives index 7.
REQ-022 Pipeline latency SHALL be exactly 2 cycles from line_coo/ver_coo/de_i to rgb_o/de_o: stage 1 registers the index, stage 2 registers the palette output.
REQ-023 rgb_o SHALL be 0000 in any cycle where de_o is 0.
REQ-024 Mode handshake: a request is accepted when mode_valid and mode_ready are both 1 on a clock edge.
REQ-025 An accepted mode SHALL be held pending; mode_ready SHALL be 0 while a mode is pending.
REQ-026 A pending mode SHALL load into mode_o on the next frame_start, and mode_ready SHALL return to 1 on the following cycle.
REQ-027 When acceptance and frame_start coincide, the new mode SHALL load into mode_o on that same edge and no pending state SHALL be entered.
REQ-028 A mode change SHALL NOT occur mid-frame; pixels already in the pipeline SHALL complete under the mode present at stage 1.
REQ-029 Offset SHALL be a WIDTH-bit counter that advances by SCROLL_STEP on each frame_start and wraps modulo 2^WIDTH.

Reset
REQ-030 While rst is 1: rgb_o = 0000, de_o = 0, mode_o = 0, mode_ready = 0, offset = 0, pending cleared, pipeline valid bits cleared.
REQ-031 mode_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-frame or with a mode pending SHALL discard the pending mode and in-flight pixels.

Configuration
REQ-033 Macro STRIPE_SCROLL_EN: when defined, the offset counter runs per REQ-029.
REQ-034 Without STRIPE_SCROLL_EN, offset SHALL be the constant 0, no counter SHALL be synthesised, and modes 0 and 2 are static.

Verification
REQ-035 Mode 0, no scroll, de_i=1, x=0/64/128/192, y=0 -> after 2 cycles rgb_o = F800/07E0/001F/F800.
REQ-036 Mode 3, H_ACTIVE=640, x=79/80/639 -> rgb_o = F800/07E0/0000; de_i=0 at any x -> rgb_o = 0000, de_o = 0.
REQ-037 Mode request 2 accepted mid-frame -> mode_ready = 0, mode_o stays 0 until frame_start, then mode_o = 2 and mode_ready = 1 next cycle; x=64, y=0 -> FFFF.
REQ-038 mode_valid with mode_req=1 coincident with frame_start -> mode_o = 1 on that edge, mode_ready stays 1.
REQ-039 STRIPE_SCROLL_EN defined, mode 0, 64 frame_start pulses, x=0 -> rgb_o = 07E0; offset wraps to 0 after 1024 pulses.
REQ-040 rst pulsed with a mode pending -> all outputs at reset values, mode_o = 0, mode_ready = 1 the cycle after release.
